// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: iterative radix-2 DIV/DIVU (and MULT/MULTU unless MULDIV_FAST_MUL_EN
// selects a single-cycle combinational multiplier); MTHI/MTLO write HI/LO directly.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushE,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic [31:0] hiE,
    output logic [31:0] loE,
    output logic        stallE,
    output logic        busyE
);

    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MTLO  = 8'h13;

`ifdef MULDIV_FAST_MUL_EN
    localparam logic MUL_ITER = 1'b0;
`else
    localparam logic MUL_ITER = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT       state;
    logic [31:0] hiReg, loReg;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] magReg;
    logic [31:0] aRaw;
    logic        divOp, negRes, negRem, divZero;

    logic        isMul, isDiv, isSigned, isMthi, isMtlo, startIter;
    logic [31:0] absA, absB;
    logic [32:0] diff, sum;
    logic [63:0] accNext, prodFix;
    logic [31:0] quot, rem, resHi, resLo;

    always_comb begin
        isMul     = (alucontrolE == OP_MULT) || (alucontrolE == OP_MULTU);
        isDiv     = (alucontrolE == OP_DIV)  || (alucontrolE == OP_DIVU);
        isSigned  = (alucontrolE == OP_MULT) || (alucontrolE == OP_DIV);
        isMthi    = (alucontrolE == OP_MTHI);
        isMtlo    = (alucontrolE == OP_MTLO);
        startIter = !flushE && (isDiv || (isMul && MUL_ITER));
        absA      = (isSigned && srcaE[31]) ? -srcaE : srcaE;
        absB      = (isSigned && srcbE[31]) ? -srcbE : srcbE;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fastProd;
    always_comb begin
        if (isSigned)
            fastProd = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
        else
            fastProd = {32'd0, srcaE} * {32'd0, srcbE};
    end
`endif

    // One radix-2 step: restoring divide on {rem, quot}, or shift-add multiply on {prodHi, multiplier}.
    always_comb begin
        diff    = acc[63:31] - {1'b0, magReg};
        sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, magReg} : 33'd0);
        accNext = acc;
        if (divOp) begin
            if (!diff[32])
                accNext = {diff[31:0], acc[30:0], 1'b1};
            else
                accNext = {acc[62:0], 1'b0};
        end else begin
            accNext = {sum, acc[31:1]};
        end
        quot    = accNext[31:0];
        rem     = accNext[63:32];
        prodFix = negRes ? -accNext : accNext;
        resHi   = prodFix[63:32];
        resLo   = prodFix[31:0];
        if (divOp) begin
            resHi = divZero ? aRaw : (negRem ? -rem : rem);
            resLo = divZero ? 32'hFFFF_FFFF : (negRes ? -quot : quot);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            cnt     <= 5'd0;
            acc     <= 64'd0;
            magReg  <= 32'd0;
            aRaw    <= 32'd0;
            divOp   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flushE) begin
                        if (isMthi)
                            hiReg <= srcaE;
                        else if (isMtlo)
                            loReg <= srcaE;
`ifdef MULDIV_FAST_MUL_EN
                        else if (isMul)
                            {hiReg, loReg} <= fastProd;
`endif
                        else if (startIter) begin
                            state   <= BUSY;
                            cnt     <= 5'd31;
                            divOp   <= isDiv;
                            aRaw    <= srcaE;
                            divZero <= isDiv && (srcbE == 32'd0);
                            negRes  <= isSigned && (srcaE[31] ^ srcbE[31]);
                            negRem  <= isDiv && isSigned && srcaE[31];
                            acc     <= isDiv ? {32'd0, absA} : {32'd0, absB};
                            magReg  <= isDiv ? absB : absA;
                        end
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        state <= IDLE;
                    end else begin
                        acc <= accNext;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            hiReg <= resHi;
                            loReg <= resLo;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hiE    = hiReg;
    assign loE    = loReg;
    assign busyE  = (state != IDLE);
    assign stallE = rst && (((state == IDLE) && startIter) || (state == BUSY));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table of HI/LO operations plus hand-written flush and reset-abort sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushE;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE, srcbE;
    logic [31:0] hiE, loE;
    logic        stallE, busyE;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .flushE(flushE), .alucontrolE(alucontrolE),
        .srcaE(srcaE), .srcbE(srcbE), .hiE(hiE), .loE(loE),
        .stallE(stallE), .busyE(busyE)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MULN = 0;
`else
    localparam int MULN = 33;
`endif
    localparam logic [7:0] NOP = 8'h00;

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vecT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prevHi, prevLo;
    vecT         vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one op, counts stall cycles, checks result and that DONE does not restart.
    task automatic runOp(input vecT v, input int idx);
        int n;
        alucontrolE = v.ctl; srcaE = v.a; srcbE = v.b; flushE = 1'b0;
        #1;
        chk($sformatf("v%0d hi before write", idx), hiE, prevHi);
        chk($sformatf("v%0d lo before write", idx), loE, prevLo);
        n = 0;
        while (stallE === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #2;
        end
        chk($sformatf("v%0d stall cycles", idx), n, v.n);
        if (v.n > 0) begin
            chk($sformatf("v%0d busy in DONE", idx), {31'd0, busyE}, 32'd1);
            chk($sformatf("v%0d hi in DONE", idx), hiE, v.hi);
            chk($sformatf("v%0d lo in DONE", idx), loE, v.lo);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d idle after", idx), {31'd0, busyE}, 32'd0);
        alucontrolE = NOP;
        #1;
        if (v.n == 0) begin
            chk($sformatf("v%0d hi", idx), hiE, v.hi);
            chk($sformatf("v%0d lo", idx), loE, v.lo);
        end
        chk($sformatf("v%0d stall low", idx), {31'd0, stallE}, 32'd0);
        prevHi = v.hi;
        prevLo = v.lo;
    endtask

    initial begin
        vecs[0]  = '{8'h11, 32'hA5A5_A5A5, 32'd0,        32'hA5A5_A5A5, 32'h0000_0000, 0};
        vecs[1]  = '{8'h13, 32'h1234_5678, 32'd0,        32'hA5A5_A5A5, 32'h1234_5678, 0};
        vecs[2]  = '{8'h1B, 32'd100,       32'd7,        32'd2,         32'd14,        33};
        vecs[3]  = '{8'h1A, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[4]  = '{8'h1B, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 33};
        vecs[5]  = '{8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
        vecs[6]  = '{8'h18, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MULN};
        vecs[7]  = '{8'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULN};
        vecs[8]  = '{8'h1A, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
        vecs[9]  = '{8'h1A, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};
        vecs[10] = '{8'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULN};
        vecs[11] = '{8'h18, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, MULN};
        vecs[12] = '{8'h12, 32'd1,         32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 0};
        vecs[13] = '{8'h1B, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 33};
        vecs[14] = '{8'h19, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780, MULN};
        vecs[15] = '{8'h1A, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 33};

        // Reset held with an iterative op presented: everything stays quiet.
        rst = 1'b0; flushE = 1'b0; alucontrolE = 8'h1B; srcaE = 32'd100; srcbE = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", {31'd0, stallE}, 32'd0);
        chk("reset busy",  {31'd0, busyE},  32'd0);
        chk("reset hi",    hiE, 32'd0);
        chk("reset lo",    loE, 32'd0);
        alucontrolE = NOP;
        rst = 1'b1;
        prevHi = 32'd0;
        prevLo = 32'd0;

        for (int i = 0; i < 16; i++)
            runOp(vecs[i], i);

        // Flush in BUSY cycle 10: abort, keep HI/LO.
        runOp('{8'h11, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, prevLo, 0}, 100);
        runOp('{8'h13, 32'h5A5A_5A5A, 32'd0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0}, 101);
        alucontrolE = 8'h1A; srcaE = 32'd100; srcbE = 32'd7;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        chk("flush busy before", {31'd0, busyE}, 32'd1);
        flushE = 1'b1;
        #1;
        chk("flush stall in cycle", {31'd0, stallE}, 32'd1);
        @(posedge clk); #1;
        flushE = 1'b0; alucontrolE = NOP;
        #1;
        chk("flush stall after", {31'd0, stallE}, 32'd0);
        chk("flush busy after",  {31'd0, busyE},  32'd0);
        chk("flush hi kept", hiE, 32'hA5A5_A5A5);
        chk("flush lo kept", loE, 32'h5A5A_5A5A);
        repeat (40) @(posedge clk);
        #1;
        chk("flush hi later", hiE, 32'hA5A5_A5A5);
        chk("flush lo later", loE, 32'h5A5A_5A5A);

        // Flush in IDLE suppresses both iterative ops and MTHI.
        alucontrolE = 8'h1B; flushE = 1'b1;
        #1;
        chk("idle flush stall", {31'd0, stallE}, 32'd0);
        @(posedge clk); #1;
        chk("idle flush busy", {31'd0, busyE}, 32'd0);
        alucontrolE = 8'h11; srcaE = 32'd1;
        @(posedge clk); #1;
        chk("idle flush mthi", hiE, 32'hA5A5_A5A5);
        flushE = 1'b0; alucontrolE = NOP;

        // Asynchronous reset in BUSY cycle 5, then first op right after release.
        alucontrolE = 8'h1B; srcaE = 32'd100; srcbE = 32'd7;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort stall", {31'd0, stallE}, 32'd0);
        chk("abort busy",  {31'd0, busyE},  32'd0);
        chk("abort hi", hiE, 32'd0);
        chk("abort lo", loE, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        prevHi = 32'd0;
        prevLo = 32'd0;
        runOp('{8'h1B, 32'd9, 32'd3, 32'd0, 32'd3, 33}, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
